// File: rtl/multi_bank_fifo.sv
// multi_bank_fifo: single-clock FIFO that hands data over one committed bank at a time.
// Banks are committed when full or flushed early with their partial length.
module multi_bank_fifo #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int B = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         w_trigger,
  input  logic [W-1:0] w_data,
  input  logic         w_flush,
  output logic         w_ok,
  output logic [B-1:0] w_bank,
  output logic         w_overflow,
  input  logic         r_trigger,
  output logic [W-1:0] r_data,
  output logic         r_ok,
  output logic         r_last,
  output logic [B-1:0] r_bank,
  output logic [B:0]   r_banks
);
  localparam int BANKS = 1 << B;
  logic [W-1:0] mem [2**(B+N)];
  logic [N-1:0] last_idx [BANKS];
  logic [N-1:0] w_word, r_word, commit_last;
  logic [B:0]   committed;
  logic         wr, rd, commit, free;
  always_comb begin
    w_ok        = committed != (B+1)'(BANKS);
    r_ok        = committed != '0;
    r_banks     = committed;
    r_data      = mem[{r_bank, r_word}];
    r_last      = r_ok && (r_word == last_idx[r_bank]);
    wr          = w_trigger && w_ok;
    rd          = r_trigger && r_ok;
    free        = rd && r_last;
    commit      = (wr && w_word == '1) || (w_flush && w_ok && (wr || w_word != '0));
    commit_last = wr ? w_word : w_word - N'(1);
  end
  always_ff @(posedge clk)
    if (wr) mem[{w_bank, w_word}] <= w_data;
  // A bank being read is never the one being committed: that would need the FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_word     <= '0;
      w_bank     <= '0;
      r_word     <= '0;
      r_bank     <= '0;
      committed  <= '0;
      w_overflow <= 1'b0;
      last_idx   <= '{default: '0};
    end else begin
      if (commit) w_word <= '0;
      else if (wr) w_word <= w_word + N'(1);
      if (commit) begin
        w_bank           <= w_bank + B'(1);
        last_idx[w_bank] <= commit_last;
      end
      if (w_trigger && !w_ok) w_overflow <= 1'b1;
      if (rd) r_word <= r_last ? '0 : r_word + N'(1);
      if (free) r_bank <= r_bank + B'(1);
      committed <= committed + (B+1)'(commit) - (B+1)'(free);
    end
  end
endmodule
